// File: rtl/dh_responder.sv
// Diffie-Hellman responder: computes B = g^b mod p and S = A^b mod p with
// right-to-left square-and-multiply, one iteration per cycle, fixed latency.
module dh_responder #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cfg_p,
  input  logic [W-1:0] cfg_g,
  input  logic [W-1:0] priv_key,
  input  logic         req_valid,
  input  logic [W-1:0] req_pub,
  output logic         req_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_pub,
  output logic [W-1:0] rsp_secret,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, EXP_PUB, EXP_SEC, RESP} state_t;

  state_t        state, state_next;
  logic [W-1:0]  p_r, a_r, b_r;
  logic [W-1:0]  p_n, a_n, b_n;
  logic [W-1:0]  acc, base, e;
  logic [W-1:0]  acc_n, base_n, e_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  pub_n, sec_n;
  logic          err_n;
  logic [W-1:0]  acc_step, base_step;

  // A zero modulus never reaches a committed register; returning 0 keeps X out.
  function automatic logic [W-1:0] mod_red(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W-1:0] r;
    r = '0;
    if (m != '0) r = x % m;
    return r;
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod, r;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    r    = '0;
    if (m != '0) r = prod % {{W{1'b0}}, m};
    return r[W-1:0];
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state == EXP_PUB) || (state == EXP_SEC);

  assign acc_step  = e[0] ? mod_mul(acc, base, p_r) : acc;
  assign base_step = mod_mul(base, base, p_r);

  always_comb begin
    state_next = state;
    p_n        = p_r;
    a_n        = a_r;
    b_n        = b_r;
    acc_n      = acc;
    base_n     = base;
    e_n        = e;
    cnt_n      = cnt;
    pub_n      = rsp_pub;
    sec_n      = rsp_secret;
    err_n      = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          p_n = cfg_p;
          a_n = req_pub;
          b_n = priv_key;
          if (cfg_p < W'(2)) begin
            pub_n      = '0;
            sec_n      = '0;
            err_n      = 1'b1;
            state_next = RESP;
          end else begin
            acc_n      = W'(1);
            base_n     = mod_red(cfg_g, cfg_p);
            e_n        = priv_key;
            cnt_n      = CW'(W);
            state_next = EXP_PUB;
          end
        end
      end
      EXP_PUB, EXP_SEC: begin
        acc_n  = acc_step;
        base_n = base_step;
        e_n    = e >> 1;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (state == EXP_PUB) begin
            pub_n      = acc_step;
            acc_n      = W'(1);
            base_n     = mod_red(a_r, p_r);
            e_n        = b_r;
            cnt_n      = CW'(W);
            state_next = EXP_SEC;
          end else begin
            sec_n      = acc_step;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          err_n      = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      base       <= '0;
      e          <= '0;
      cnt        <= '0;
      rsp_pub    <= '0;
      rsp_secret <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_n;
      base       <= base_n;
      e          <= e_n;
      cnt        <= cnt_n;
      rsp_pub    <= pub_n;
      rsp_secret <= sec_n;
      rsp_err    <= err_n;
    end
  end

  // Captured operands are only read after capture, so they need no reset.
  always_ff @(posedge clk) begin
    p_r <= p_n;
    a_r <= a_n;
    b_r <= b_n;
  end

endmodule
